// File: rtl/dnn_input_feeder.sv
// dnn_input_feeder: double-buffered training-sample feeder for the DNN input
// junction. A valid/ready source fills one bank while the other bank is
// replayed, one chunk per clock, in step with the network cycle_index.
// Optional build macro: DNN_FEEDER_STATS_EN adds saturating valid/bubble
// block counters (sample_count, bubble_count).
module dnn_input_feeder #(
    parameter int width_in     = 8,
    parameter int zbyfo0       = 64,
    parameter int zbyfiL       = 1,
    parameter int cpc          = 18,
    parameter int etapos_width = 4,
    parameter logic [etapos_width-1:0] idle_etapos = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(cpc)-1:0]       cycle_index,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [width_in*zbyfo0-1:0]   in_act,
    input  logic [zbyfiL-1:0]            in_ans,
    input  logic [etapos_width-1:0]      in_etapos,
    output logic [width_in*zbyfo0-1:0]   act0,
    output logic [zbyfiL-1:0]            ans0,
    output logic [etapos_width-1:0]      etapos0,
`ifdef DNN_FEEDER_STATS_EN
    output logic [31:0]                  sample_count,
    output logic [31:0]                  bubble_count,
`endif
    output logic                         sample_valid
);

    localparam int AW  = width_in * zbyfo0;
    localparam int NCH = cpc - 2;
    localparam int CIW = $clog2(cpc);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CIW-1:0] CI_LAST   = CIW'(cpc - 1);
    localparam logic [CIW-1:0] CI_NCH    = CIW'(NCH);
    localparam logic [CHW-1:0] BEAT_LAST = CHW'(NCH - 1);

    if (cpc < 3) begin : g_bad_cpc
        $error("dnn_input_feeder: cpc must be at least 3");
    end

    // Bank storage; index 0/1 selects the bank, ptr_q names the read bank.
    logic [AW-1:0]           act_mem_q [2][NCH];
    logic [zbyfiL-1:0]       ans_mem_q [2][NCH];
    logic [etapos_width-1:0] eta_mem_q [2];

    logic           ptr_q, ptr_d;
    logic           fill_full_q, fill_full_d;
    logic [CHW-1:0] beat_q, beat_d;
    logic           sample_valid_q, sample_valid_d;

    logic           accept;
    logic           boundary;
    logic           fill_bank;
    logic [CHW-1:0] rd_idx;

    assign accept    = in_valid && !fill_full_q;
    assign boundary  = (cycle_index == CI_LAST);
    assign fill_bank = ~ptr_q;
    assign rd_idx    = cycle_index[CHW-1:0];

    // Fill counter and block-boundary swap decision. A fill can only complete
    // when fill_full is clear and a swap needs it set, so the two never collide;
    // a fill finishing on the boundary edge therefore waits one more block.
    always_comb begin
        ptr_d          = ptr_q;
        fill_full_d    = fill_full_q;
        beat_d         = beat_q;
        sample_valid_d = sample_valid_q;

        if (accept) begin
            if (beat_q == BEAT_LAST) begin
                beat_d      = '0;
                fill_full_d = 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        if (boundary) begin
            if (fill_full_q) begin
                ptr_d          = ~ptr_q;
                fill_full_d    = 1'b0;
                sample_valid_d = 1'b1;
            end else begin
                sample_valid_d = 1'b0;
            end
        end
    end

    // Control state register; reset drops any partially or fully buffered sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q          <= 1'b0;
            fill_full_q    <= 1'b0;
            beat_q         <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            fill_full_q    <= fill_full_d;
            beat_q         <= beat_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    // Bank writes; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (accept) begin
            act_mem_q[fill_bank][beat_q] <= in_act;
            ans_mem_q[fill_bank][beat_q] <= in_ans;
            if (beat_q == '0) begin
                eta_mem_q[fill_bank] <= in_etapos;
            end
        end
    end

    // Replay mux: combinational from read bank and cycle_index, zero in the
    // two trailing slots of a block and throughout bubble blocks.
    always_comb begin
        act0    = '0;
        ans0    = '0;
        etapos0 = idle_etapos;
        if (sample_valid_q) begin
            etapos0 = eta_mem_q[ptr_q];
            if (cycle_index < CI_NCH) begin
                act0 = act_mem_q[ptr_q][rd_idx];
                ans0 = ans_mem_q[ptr_q][rd_idx];
            end
        end
    end

    assign in_ready     = !fill_full_q;
    assign sample_valid = sample_valid_q;

`ifdef DNN_FEEDER_STATS_EN
    logic [31:0] sample_count_q, sample_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    // Saturating counts of valid and bubble blocks started at each boundary.
    always_comb begin
        sample_count_d = sample_count_q;
        bubble_count_d = bubble_count_q;
        if (boundary) begin
            if (fill_full_q) begin
                if (sample_count_q != '1) sample_count_d = sample_count_q + 32'd1;
            end else begin
                if (bubble_count_q != '1) bubble_count_d = bubble_count_q + 32'd1;
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_count_q <= '0;
            bubble_count_q <= '0;
        end else begin
            sample_count_q <= sample_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign sample_count = sample_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: doc/dnn_input_feeder.md
# dnn_input_feeder

Double-buffered training-sample feeder sitting directly upstream of the top-level DNN. It accepts one sample at a time over a valid/ready chunk interface: activation chunks, ideal-output chunks and one etapos value. It then replays the sample in lock-step with the network's `cycle_index`, driving `act0`, `ans0` and `etapos0` one chunk per clock. While one bank is replayed the other bank fills, so back-to-back samples stream with no bubbles when the source keeps up.

## Interface
- `width_in`, 8: bits per input activation.
- `zbyfo0`, 64: activations per clock into junction 1 (z[0]/fo[0]).
- `zbyfiL`, 1: ideal-output bits per clock (z[L-2]/fi[L-2]).
- `cpc`, 18: clocks per block cycle; data chunks per sample = `cpc`-2.
- `etapos_width`, 4: etapos width ($clog2(frac_bits+2)).
- `idle_etapos`, 0: etapos driven during bubble blocks.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cycle_index` in $clog2(cpc): block-cycle counter from the network's cycle counter.
- `in_valid` in 1: source beat valid.
- `in_ready` out 1: feeder can accept a beat.
- `in_act` in width_in*zbyfo0: activation chunk.
- `in_ans` in zbyfiL: ideal-output chunk.
- `in_etapos` in etapos_width: sample etapos, sampled on beat 0 only.
- `act0` out width_in*zbyfo0: to network act0.
- `ans0` out zbyfiL: to network ans0.
- `etapos0` out etapos_width: to network etapos0.
- `sample_valid` out 1: current block carries a real sample.

## Operation
- Two banks, each holding `cpc`-2 act chunks, `cpc`-2 ans chunks and one etapos. Roles are the read bank and the fill bank, selected by a 1-bit pointer.
- Fill side:
  - A beat is accepted when `in_valid && in_ready`.
  - Beat k is written to chunk k of the fill bank (k = 0..`cpc`-3). `in_etapos` is captured on k=0.
  - The beat counter increments per accepted beat. On accepting beat `cpc`-3, `fill_full` is set and the counter wraps to 0.
  - `in_ready` = !`fill_full`.
- Read side, at the edge where `cycle_index`==`cpc`-1:
  - If `fill_full` is set: flip the pointer, clear `fill_full`, set `sample_valid`=1.
  - Otherwise: `sample_valid`=0, which marks a bubble block.
- Outputs, combinational from the read bank:
  - While `sample_valid`=1 and `cycle_index`<`cpc`-2: `act0`/`ans0` = read-bank chunk[`cycle_index`].
  - `cycle_index` ∈ {`cpc`-2, `cpc`-1}: `act0`/`ans0` = 0.
  - `etapos0` = read-bank etapos for the whole block.
- Bubble block (`sample_valid`=0): `act0`=0, `ans0`=0, `etapos0`=`idle_etapos`.
- Simultaneous events:
  - Final fill beat accepted on the same edge as `cycle_index`==`cpc`-1: the swap uses the pre-edge `fill_full` (0). The next block is a bubble and the swap happens at the following boundary. There is no bypass.
  - Swap with `in_valid` high: `in_ready` rises the clock after the swap. A beat accepted that clock writes chunk 0 of the freed bank.
- Elaboration check: `$error` if `cpc`<3.

## Timing
- Reset values: `in_ready`=1, `sample_valid`=0, `act0`=0, `ans0`=0, `etapos0`=`idle_etapos`. Pointer = 0, `fill_full`=0, beat counter = 0.
- Reset mid-fill or mid-replay discards all buffered data. Bank contents need not be cleared.
- Latency:
  - First block after reset is always a bubble.
  - A sample whose last beat is accepted before the `cpc`-1 edge is presented starting at the next `cycle_index`==0.
- Throughput: at 1 beat/clock a fill takes `cpc`-2 clocks, which is less than `cpc`. A continuous source gives continuous valid blocks.
- Outputs are combinational from registered state plus `cycle_index`. They have no clock-to-output latency relative to `cycle_index`.

## Configuration
- `DNN_FEEDER_STATS_EN` defined: adds two extra output ports, reset to 0 and saturating at all-ones:
  - `sample_count` (32b): increments at each boundary producing a valid block.
  - `bubble_count` (32b): increments at each boundary producing a bubble block.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then idle source for 3 blocks (`cpc`=18) -> `sample_valid`=0, `act0`=0, `etapos0`=`idle_etapos` throughout; `in_ready`=1.
- Stream one sample, chunk k = k+1, `in_etapos`=5, completed before boundary -> next block: `act0`=k+1 at `cycle_index`=k for k=0..15, 0 at 16/17; `etapos0`=5; `sample_valid`=1.
- Continuous 1 beat/clock source for 10 samples -> 10 consecutive valid blocks with no bubble; each sample's data matches its own etapos.
- Last beat accepted exactly at `cycle_index`=17 -> following block is a bubble, and the sample appears one block later.
- Both banks full with `in_valid` held -> `in_ready`=0 until the swap edge, then 1 the next clock; no beat is lost or duplicated.
- Reset asserted after 7 beats of a fill -> next sample presented contains only post-reset beats; with `DNN_FEEDER_STATS_EN`, both counters read 0 after reset.
